// File: rtl/multicycle_control.sv
// Multicycle processor control unit.
// Sequences each instruction through FETCH/DECODE and a class-specific tail,
// drives the datapath strobes and selects, counts retired instructions and
// parks in a sticky ILLEGAL state on an unknown opcode until reset.
//
// Memory handshake: while a memory access is pending, the controller holds
// mem_read or mem_write (with iord) asserted every cycle. The access completes
// on the rising edge where mem_ready=1; with mem_ready=0 the controller waits.
// mem_ready is only looked at in FETCH, MEMREAD and MEMWRITE.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             pc_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_ILLEGAL  = 4'd10
    } state_t;

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    state_t           state_q;
    state_t           state_d;
    logic             illegal_q;
    logic [CNT_W-1:0] count_q;
    logic             retire;

    // Ungated strobes; reset masks the ones that could disturb the datapath.
    logic pc_write_raw;
    logic ir_write_raw;
    logic mem_read_raw;
    logic mem_write_raw;
    logic reg_write_raw;

    // State register, sticky illegal flag and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == S_ILLEGAL) begin
                illegal_q <= 1'b1;
            end
            if (retire) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    // Next-state selection and per-state datapath controls.
    always_comb begin
        state_d       = state_q;
        retire        = 1'b0;
        pc_write_raw  = 1'b0;
        ir_write_raw  = 1'b0;
        mem_read_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        iord          = 1'b0;
        mem_to_reg    = 1'b0;
        pc_src        = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        case (state_q)
            S_FETCH: begin
                // PC + 4 computed while the instruction word is read.
                mem_read_raw = 1'b1;
                alu_src_b    = 2'b01;
                if (mem_ready) begin
                    ir_write_raw = 1'b1;
                    pc_write_raw = 1'b1;
                    state_d      = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target precomputed from the old PC.
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
                case (opcode)
                    OP_LD, OP_SD: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC_R;
                    OP_I:         state_d = S_EXEC_I;
                    OP_BR:        state_d = S_BRANCH;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_LD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_read_raw = 1'b1;
                iord         = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                reg_write_raw = 1'b1;
                mem_to_reg    = 1'b1;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_write_raw = 1'b1;
                iord          = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC_R: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b00;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a    = 2'b01;
                alu_src_b    = 2'b00;
                alu_op       = 2'b01;
                pc_src       = 1'b1;
                pc_write_raw = zero;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            S_ILLEGAL: begin
                state_d = S_ILLEGAL;
            end
            default: begin
                // Unused encodings recover to FETCH.
                state_d = S_FETCH;
            end
        endcase
    end

    assign pc_write    = pc_write_raw  & ~reset;
    assign ir_write    = ir_write_raw  & ~reset;
    assign mem_read    = mem_read_raw  & ~reset;
    assign mem_write   = mem_write_raw & ~reset;
    assign reg_write   = reg_write_raw & ~reset;
    assign state       = state_q;
    assign illegal     = illegal_q;
    assign instr_count = count_q;

endmodule
